// File: rtl/rtc_wr_cycle.sv
// Purpose     : write-side master for the RTC multiplexed address/data bus; runs one
//               address phase, an idle gap and one data phase per accepted start.
// Latency     : start sampled at edge k -> cs_n low from k+1; done pulses at
//               k+1+2*(T_SETUP+T_PULSE+T_HOLD)+T_GAP.
// Backpressure: none queued; start is only sampled in IDLE, and ignored while busy or in DONE.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-low reset
//   start               request a write (IDLE only); wr_addr/wr_data captured with it
//   busy, done          transaction in progress / one-cycle completion pulse
//   bus_out, bus_oe     AD bus value and pad output enable
//   ad_sel, cs_n, wr_n  address/data select, chip select, write strobe
//   rd_n                read strobe, held inactive
module rtc_wr_cycle #(
    parameter int T_SETUP = 2,
    parameter int T_PULSE = 4,
    parameter int T_HOLD  = 2,
    parameter int T_GAP   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    output logic       ad_sel,
    output logic       cs_n,
    output logic       wr_n,
    output logic       rd_n
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_A_SETUP,
        S_A_PULSE,
        S_A_HOLD,
        S_GAP,
        S_D_SETUP,
        S_D_PULSE,
        S_D_HOLD,
        S_DONE
    } state_t;

    // Counter holds "cycles remaining minus one" in the current state, so each
    // state is entered with its length-1 and left when the counter reads zero.
    localparam logic [7:0] SETUP_LD = 8'(T_SETUP - 1);
    localparam logic [7:0] PULSE_LD = 8'(T_PULSE - 1);
    localparam logic [7:0] HOLD_LD  = 8'(T_HOLD - 1);
    localparam logic [7:0] GAP_LD   = 8'(T_GAP - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;

    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] bus_out_q, bus_out_d;
    logic       bus_oe_q, bus_oe_d;
    logic       ad_sel_q, ad_sel_d;
    logic       cs_n_q, cs_n_d;
    logic       wr_n_q, wr_n_d;

    logic       cnt_zero;
    assign cnt_zero = (cnt_q == 8'd0);

    // Next-state and counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_A_SETUP;
                    cnt_d   = SETUP_LD;
                    addr_d  = wr_addr;
                    data_d  = wr_data;
                end
            end
            S_A_SETUP: begin
                if (cnt_zero) begin
                    state_d = S_A_PULSE;
                    cnt_d   = PULSE_LD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_A_PULSE: begin
                if (cnt_zero) begin
                    state_d = S_A_HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_A_HOLD: begin
                if (cnt_zero) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_GAP: begin
                if (cnt_zero) begin
                    state_d = S_D_SETUP;
                    cnt_d   = SETUP_LD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_D_SETUP: begin
                if (cnt_zero) begin
                    state_d = S_D_PULSE;
                    cnt_d   = PULSE_LD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_D_PULSE: begin
                if (cnt_zero) begin
                    state_d = S_D_HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_D_HOLD: begin
                if (cnt_zero) begin
                    state_d = S_DONE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Outputs are decoded from the *next* state and then registered, so the
    // pins change on the same edge the state does and never see a comb path
    // from the inputs. cs_n and bus_oe share one decode, keeping them aligned.
    always_comb begin
        busy_d    = 1'b0;
        done_d    = 1'b0;
        bus_out_d = 8'd0;
        bus_oe_d  = 1'b0;
        ad_sel_d  = 1'b0;
        cs_n_d    = 1'b1;
        wr_n_d    = 1'b1;
        unique case (state_d)
            S_A_SETUP, S_A_PULSE, S_A_HOLD: begin
                busy_d    = 1'b1;
                bus_out_d = addr_d;
                bus_oe_d  = 1'b1;
                cs_n_d    = 1'b0;
                wr_n_d    = (state_d != S_A_PULSE);
            end
            S_GAP: begin
                busy_d = 1'b1;
            end
            S_D_SETUP, S_D_PULSE, S_D_HOLD: begin
                busy_d    = 1'b1;
                bus_out_d = data_d;
                bus_oe_d  = 1'b1;
                ad_sel_d  = 1'b1;
                cs_n_d    = 1'b0;
                wr_n_d    = (state_d != S_D_PULSE);
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            addr_q    <= 8'd0;
            data_q    <= 8'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bus_out_q <= 8'd0;
            bus_oe_q  <= 1'b0;
            ad_sel_q  <= 1'b0;
            cs_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bus_out_q <= bus_out_d;
            bus_oe_q  <= bus_oe_d;
            ad_sel_q  <= ad_sel_d;
            cs_n_q    <= cs_n_d;
            wr_n_q    <= wr_n_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bus_out = bus_out_q;
    assign bus_oe  = bus_oe_q;
    assign ad_sel  = ad_sel_q;
    assign cs_n    = cs_n_q;
    assign wr_n    = wr_n_q;
    assign rd_n    = 1'b1;

endmodule

// File: tb/tb_rtc_wr_cycle.sv
// Bench for rtc_wr_cycle: default-timing instance plus a minimum-timing instance.
// Expected pin values come from a phase-arithmetic model of one transaction.
// Each scenario task compares all pins every cycle against that model.
module tb_rtc_wr_cycle;

    localparam int TS = 2, TP = 4, TH = 2, TG = 4;
    localparam int DONE_E = 2 * (TS + TP + TH) + TG;   // offset of done from first busy cycle

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0, start_f = 1'b0;
    logic [7:0] wr_addr = 8'd0, wr_data = 8'd0, wr_addr_f = 8'd0, wr_data_f = 8'd0;

    logic       busy, done, bus_oe, ad_sel, cs_n, wr_n, rd_n;
    logic [7:0] bus_out;
    logic       busy_f, done_f, bus_oe_f, ad_sel_f, cs_n_f, wr_n_f, rd_n_f;
    logic [7:0] bus_out_f;

    logic [14:0] obs, obs_f;
    assign obs   = {busy, done, bus_out, bus_oe, ad_sel, cs_n, wr_n, rd_n};
    assign obs_f = {busy_f, done_f, bus_out_f, bus_oe_f, ad_sel_f, cs_n_f, wr_n_f, rd_n_f};

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    rtc_wr_cycle dut (
        .clk(clk), .reset(reset), .start(start), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .bus_out(bus_out), .bus_oe(bus_oe), .ad_sel(ad_sel),
        .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n)
    );

    rtc_wr_cycle #(.T_SETUP(1), .T_PULSE(1), .T_HOLD(1), .T_GAP(1)) dut_f (
        .clk(clk), .reset(reset), .start(start_f), .wr_addr(wr_addr_f), .wr_data(wr_data_f),
        .busy(busy_f), .done(done_f), .bus_out(bus_out_f), .bus_oe(bus_oe_f), .ad_sel(ad_sel_f),
        .cs_n(cs_n_f), .wr_n(wr_n_f), .rd_n(rd_n_f)
    );

    // Pins expected e cycles after the first busy cycle of a transaction
    // (e<0 or past done means idle). Packed as {busy,done,bus_out,oe,ad_sel,cs_n,wr_n,rd_n}.
    function automatic logic [14:0] model(input int e, input logic [7:0] a, input logic [7:0] d,
                                          input int ts, input int tp, input int th, input int tg);
        int p, off;
        logic b, dn, oe, ads, cs, wr;
        logic [7:0] bo;
        b = 1'b0; dn = 1'b0; oe = 1'b0; ads = 1'b0; cs = 1'b1; wr = 1'b1; bo = 8'd0;
        p = ts + tp + th;
        if (e >= 0 && e < p) begin
            b = 1'b1; oe = 1'b1; cs = 1'b0; bo = a;
            wr = !(e >= ts && e < ts + tp);
        end else if (e >= p && e < p + tg) begin
            b = 1'b1;
        end else if (e >= p + tg && e < 2 * p + tg) begin
            off = e - p - tg;
            b = 1'b1; oe = 1'b1; cs = 1'b0; ads = 1'b1; bo = d;
            wr = !(off >= ts && off < ts + tp);
        end else if (e == 2 * p + tg) begin
            dn = 1'b1;
        end
        return {b, dn, bo, oe, ads, cs, wr, 1'b1};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [14:0] exp;
        exp = model(-1, 8'd0, 8'd0, TS, TP, TH, TG);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start   = 1'($urandom);
            wr_addr = 8'($urandom);
            wr_data = 8'($urandom);
            tick();
            n_chk++;
            if (obs !== exp) $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i, obs, exp);
            else n_pass++;
        end
        start = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_chk++;
            if (obs !== exp) $display("FAIL reset_release cyc=%0d got=%h exp=%h", i, obs, exp);
            else n_pass++;
            n_chk++;
            if (obs_f !== exp) $display("FAIL reset_fast cyc=%0d got=%h exp=%h", i, obs_f, exp);
            else n_pass++;
        end
    endtask

    task automatic test_write(input logic [7:0] a, input logic [7:0] d, input bool_ignore);
        logic [14:0] exp;
        start = 1'b1; wr_addr = a; wr_data = d;
        tick();
        start = 1'b0;
        wr_addr = 8'($urandom); wr_data = 8'($urandom);
        for (int e = 0; e <= DONE_E + 2; e++) begin
            exp = model(e, a, d, TS, TP, TH, TG);
            n_chk++;
            if (obs !== exp) $display("FAIL write a=%h e=%0d got=%h exp=%h", a, e, obs, exp);
            else n_pass++;
            if (bool_ignore && e == 3) begin
                start = 1'b1; wr_addr = 8'hFF; wr_data = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  a1, d1, a2, d2;
        logic [14:0] exp;
        int          pulses;
        a1 = 8'($urandom); d1 = 8'($urandom); a2 = 8'($urandom); d2 = 8'($urandom);
        pulses = 0;
        start = 1'b1; wr_addr = a1; wr_data = d1;
        tick();
        for (int e = 0; e < 2 * (DONE_E + 2) + 2; e++) begin
            exp = (e < DONE_E + 2) ? model(e, a1, d1, TS, TP, TH, TG)
                                   : model(e - (DONE_E + 2), a2, d2, TS, TP, TH, TG);
            n_chk++;
            if (obs !== exp) $display("FAIL b2b e=%0d got=%h exp=%h", e, obs, exp);
            else n_pass++;
            if (done) pulses++;
            if (e == 3) begin wr_addr = a2; wr_data = d2; end
            if (e == DONE_E + 2) start = 1'b0;
            tick();
        end
        n_chk++;
        if (pulses != 2) $display("FAIL b2b_done_count got=%0d exp=2", pulses);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [7:0]  a, d;
        logic [14:0] exp, idle;
        a = 8'($urandom); d = 8'($urandom);
        idle = model(-1, 8'd0, 8'd0, TS, TP, TH, TG);
        start = 1'b1; wr_addr = a; wr_data = d;
        tick();
        start = 1'b0;
        for (int e = 0; e <= 15; e++) begin
            exp = model(e, a, d, TS, TP, TH, TG);
            n_chk++;
            if (obs !== exp) $display("FAIL rst_mid_pre e=%0d got=%h exp=%h", e, obs, exp);
            else n_pass++;
            if (e == 15) reset = 1'b0;   // state is D_PULSE here
            tick();
        end
        n_chk++;
        if (obs !== idle) $display("FAIL rst_mid_edge got=%h exp=%h", obs, idle);
        else n_pass++;
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_chk++;
            if (obs !== idle) $display("FAIL rst_mid_after cyc=%0d got=%h exp=%h", i, obs, idle);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [7:0]  a, d;
        logic [14:0] exp, idle;
        idle = model(-1, 8'd0, 8'd0, TS, TP, TH, TG);
        for (int t = 0; t < 8; t++) begin
            a = 8'($urandom); d = 8'($urandom);
            for (int g = 0; g < int'($urandom_range(3, 0)); g++) begin
                tick();
                n_chk++;
                if (obs !== idle) $display("FAIL rand_idle t=%0d got=%h exp=%h", t, obs, idle);
                else n_pass++;
            end
            start = 1'b1; wr_addr = a; wr_data = d;
            tick();
            for (int e = 0; e <= DONE_E + 1; e++) begin
                exp = model(e, a, d, TS, TP, TH, TG);
                n_chk++;
                if (obs !== exp) $display("FAIL rand t=%0d e=%0d got=%h exp=%h", t, e, obs, exp);
                else n_pass++;
                start   = (e <= DONE_E) ? 1'($urandom) : 1'b0;
                wr_addr = 8'($urandom);
                wr_data = 8'($urandom);
                tick();
            end
        end
    endtask

    task automatic test_fast();
        logic [7:0]  a, d;
        logic [14:0] exp;
        int          low_cnt;
        a = 8'($urandom); d = 8'($urandom);
        low_cnt = 0;
        start_f = 1'b1; wr_addr_f = a; wr_data_f = d;
        tick();
        start_f = 1'b0;
        for (int e = 0; e <= 9; e++) begin
            exp = model(e, a, d, 1, 1, 1, 1);
            n_chk++;
            if (obs_f !== exp) $display("FAIL fast e=%0d got=%h exp=%h", e, obs_f, exp);
            else n_pass++;
            if (!wr_n_f) low_cnt++;
            tick();
        end
        n_chk++;
        if (low_cnt != 2) $display("FAIL fast_wr_low_cycles got=%0d exp=2", low_cnt);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write(8'h21, 8'h45, 1'b0);
        test_write(8'h21, 8'h45, 1'b1);
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_fast();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
